// File: rtl/wb_cp0_requester_pkg.sv
// Shared types for the writeback / CP0 interface: pipeline payload from MEM,
// the CP0 access bus, exception codes and the writeback FSM state.
package wb_cp0_requester_pkg;

  localparam int CPU_DATA_WIDTH = 32;

  localparam logic [CPU_DATA_WIDTH-1:0] EXCEPTION_VECTOR_DEFAULT = 32'hbfc00380;

  // CP0 Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef struct packed {
    logic [CPU_DATA_WIDTH-1:0] pc;
    logic [4:0]                dest;
    logic [CPU_DATA_WIDTH-1:0] result;
    logic                      is_mtc0;
    logic                      is_mfc0;
    logic                      is_eret;
    logic                      exception_valid;
    logic [4:0]                exception_code;
    logic                      in_delay_slot;
    logic [4:0]                cp0_register;
    logic [2:0]                cp0_select;
    logic [CPU_DATA_WIDTH-1:0] rt_value;
  } MSToWSData;

  typedef struct packed {
    logic                      write_enabled;
    logic [4:0]                address_register;
    logic [2:0]                address_select;
    logic [CPU_DATA_WIDTH-1:0] write_data;
    logic                      exception_valid;
    logic                      eret_flush;
    logic [4:0]                exception_code;
    logic [CPU_DATA_WIDTH-1:0] exception_pc;
    logic                      in_delay_slot;
  } WBToCP0Data;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    DRAIN = 2'd2
  } WsState;

endpackage

// File: rtl/wb_cp0_requester_commit_select.sv
// Priority encoder that turns the latched writeback instruction into the
// CP0 bus strobes, the regfile write and the pipeline flush/redirect.
module wb_commit_select
  import wb_cp0_requester_pkg::*;
#(
  parameter logic [CPU_DATA_WIDTH-1:0] EXCEPTION_VECTOR = EXCEPTION_VECTOR_DEFAULT
) (
  input  logic                      commit_vld,
  input  MSToWSData                 ws_bus,
  input  logic [CPU_DATA_WIDTH-1:0] cp0_read_data,
  input  logic [CPU_DATA_WIDTH-1:0] cp0_epc,
  output WBToCP0Data                wb_to_cp0_data_bus,
  output logic                      rf_write_enable,
  output logic [4:0]                rf_write_address,
  output logic [CPU_DATA_WIDTH-1:0] rf_write_data,
  output logic                      flush,
  output logic [CPU_DATA_WIDTH-1:0] flush_pc
);

  // Exception beats eret beats mtc0 beats mfc0 beats a plain writeback;
  // every strobe stays low unless an instruction is committing.
  always_comb begin
    wb_to_cp0_data_bus                  = '0;
    wb_to_cp0_data_bus.address_register = ws_bus.cp0_register;
    wb_to_cp0_data_bus.address_select   = ws_bus.cp0_select;
    wb_to_cp0_data_bus.write_data       = ws_bus.rt_value;
    wb_to_cp0_data_bus.exception_code   = ws_bus.exception_code;
    wb_to_cp0_data_bus.exception_pc     = ws_bus.pc;
    wb_to_cp0_data_bus.in_delay_slot    = ws_bus.in_delay_slot;
    rf_write_enable  = 1'b0;
    rf_write_address = ws_bus.dest;
    rf_write_data    = ws_bus.is_mfc0 ? cp0_read_data : ws_bus.result;
    flush            = 1'b0;
    flush_pc         = EXCEPTION_VECTOR;
    if (commit_vld) begin
      if (ws_bus.exception_valid) begin
        wb_to_cp0_data_bus.exception_valid = 1'b1;
        flush    = 1'b1;
        flush_pc = EXCEPTION_VECTOR;
      end else if (ws_bus.is_eret) begin
        wb_to_cp0_data_bus.eret_flush = 1'b1;
        flush    = 1'b1;
        flush_pc = cp0_epc;
      end else if (ws_bus.is_mtc0) begin
        wb_to_cp0_data_bus.write_enabled = 1'b1;
      end else begin
        // mfc0 and ordinary results both retire to the regfile; r0 is never written
        rf_write_enable = (ws_bus.dest != 5'd0);
      end
    end
  end

endmodule

// File: rtl/wb_cp0_requester.sv
// Writeback front end: holds one retiring instruction, commits it to CP0 /
// regfile in a single cycle, and drains one cycle after any flush.
module wb_cp0_requester
  import wb_cp0_requester_pkg::*;
#(
  parameter logic [CPU_DATA_WIDTH-1:0] EXCEPTION_VECTOR = EXCEPTION_VECTOR_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ms_to_ws_valid,
  input  MSToWSData                 ms_to_ws_bus,
  output logic                      ws_allow_in,
  output WBToCP0Data                wb_to_cp0_data_bus,
  input  logic [CPU_DATA_WIDTH-1:0] cp0_read_data,
  input  logic [CPU_DATA_WIDTH-1:0] cp0_epc,
  output logic                      rf_write_enable,
  output logic [4:0]                rf_write_address,
  output logic [CPU_DATA_WIDTH-1:0] rf_write_data,
  output logic                      flush,
  output logic [CPU_DATA_WIDTH-1:0] flush_pc
);

  WsState    state_p0;
  WsState    state_next;
  MSToWSData ws_bus_p0;
  logic      latch_en;
  logic      commit_vld;

  // State register; reset lands in EMPTY from any state
  always_ff @(posedge clock) begin
    if (reset) state_p0 <= EMPTY;
    else       state_p0 <= state_next;
  end

  // Instruction latch; contents are don't-care while nothing is held
  always_ff @(posedge clock) begin
    if (latch_en) ws_bus_p0 <= ms_to_ws_bus;
  end

  // Next state: a flushing commit forces one DRAIN cycle before new work
  always_comb begin
    state_next = EMPTY;
    case (state_p0)
      EMPTY:   state_next = ms_to_ws_valid ? VALID : EMPTY;
      VALID: begin
        if (flush)               state_next = DRAIN;
        else if (ms_to_ws_valid) state_next = VALID;
        else                     state_next = EMPTY;
      end
      DRAIN:   state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Control outputs; reset suppresses the commit so no strobe escapes that cycle
  always_comb begin
    ws_allow_in = (state_p0 != DRAIN);
    commit_vld  = (state_p0 == VALID) && !reset;
    latch_en    = ms_to_ws_valid && ws_allow_in && !flush && !reset;
  end

  wb_commit_select #(
    .EXCEPTION_VECTOR (EXCEPTION_VECTOR)
  ) u_commit_select (
    .commit_vld         (commit_vld),
    .ws_bus             (ws_bus_p0),
    .cp0_read_data      (cp0_read_data),
    .cp0_epc            (cp0_epc),
    .wb_to_cp0_data_bus (wb_to_cp0_data_bus),
    .rf_write_enable    (rf_write_enable),
    .rf_write_address   (rf_write_address),
    .rf_write_data      (rf_write_data),
    .flush              (flush),
    .flush_pc           (flush_pc)
  );

endmodule

// File: tb/tb_wb_cp0_requester.sv
// Bench for wb_cp0_requester: directed scenarios followed by random traffic,
// all checked against an instruction-level reference model with its own CP0 copy.
module tb_wb_cp0_requester;
  import wb_cp0_requester_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  MSToWSData   ms_to_ws_bus;
  logic        ws_allow_in;
  WBToCP0Data  wb_to_cp0_data_bus;
  logic [31:0] cp0_read_data;
  logic [31:0] cp0_epc;
  logic        rf_write_enable;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_data;
  logic        flush;
  logic [31:0] flush_pc;

  wb_cp0_requester dut (
    .clock              (clock),
    .reset              (reset),
    .ms_to_ws_valid     (ms_to_ws_valid),
    .ms_to_ws_bus       (ms_to_ws_bus),
    .ws_allow_in        (ws_allow_in),
    .wb_to_cp0_data_bus (wb_to_cp0_data_bus),
    .cp0_read_data      (cp0_read_data),
    .cp0_epc            (cp0_epc),
    .rf_write_enable    (rf_write_enable),
    .rf_write_address   (rf_write_address),
    .rf_write_data      (rf_write_data),
    .flush              (flush),
    .flush_pc           (flush_pc)
  );

  always #5 clock = ~clock;

  // Environment CP0 register file: combinational read, written on DUT strobe
  logic [31:0] cp0_mem [256];
  always_comb cp0_read_data = cp0_mem[{wb_to_cp0_data_bus.address_register,
                                       wb_to_cp0_data_bus.address_select}];
  always @(posedge clock) begin
    if (wb_to_cp0_data_bus.write_enabled === 1'b1)
      cp0_mem[{wb_to_cp0_data_bus.address_register, wb_to_cp0_data_bus.address_select}]
        <= wb_to_cp0_data_bus.write_data;
  end

  // Reference model: the instruction waiting to retire, whether WB is draining,
  // and the CP0 contents as the architecture says they should be.
  logic [31:0] ref_cp0 [256];
  logic        ref_held;
  logic        ref_drain;
  MSToWSData   ref_ins;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // kind: 0 plain result, 1 mtc0, 2 mfc0, 3 eret, 4 mtc0+mfc0 both flagged
  function automatic MSToWSData mk(input int kind, input logic exc, input logic [4:0] dest,
                                   input logic [4:0] creg, input logic [2:0] csel,
                                   input logic [31:0] val);
    MSToWSData b;
    b.pc              = $urandom;
    b.dest            = dest;
    b.result          = $urandom;
    b.is_mtc0         = (kind == 1) || (kind == 4);
    b.is_mfc0         = (kind == 2) || (kind == 4);
    b.is_eret         = (kind == 3);
    b.exception_valid = exc;
    b.exception_code  = 5'($urandom_range(0, 31));
    b.in_delay_slot   = 1'($urandom_range(0, 1));
    b.cp0_register    = creg;
    b.cp0_select      = csel;
    b.rt_value        = val;
    return b;
  endfunction

  function automatic MSToWSData rnd_ins();
    int r;
    int kind;
    r = int'($urandom_range(0, 9));
    if (r < 4)      kind = 0;
    else if (r < 6) kind = 1;
    else if (r < 8) kind = 2;
    else if (r < 9) kind = 3;
    else            kind = 4;
    return mk(kind, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              5'($urandom_range(12, 14)), 3'($urandom_range(0, 1)), $urandom);
  endfunction

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model
  task automatic cycle(input logic v, input MSToWSData b, input logic r, input logic [31:0] epc);
    logic exp_wen, exp_exc, exp_eret, exp_rfwe, exp_flush;
    logic [31:0] exp_fpc, exp_rfd;
    ms_to_ws_valid = v;
    ms_to_ws_bus   = b;
    reset          = r;
    cp0_epc        = epc;
    @(negedge clock);
    exp_wen = 0; exp_exc = 0; exp_eret = 0; exp_rfwe = 0; exp_flush = 0;
    exp_fpc = 32'h0; exp_rfd = 32'h0;
    if (ref_held && !r) begin
      if (ref_ins.exception_valid) begin
        exp_exc = 1; exp_flush = 1; exp_fpc = 32'hbfc00380;
      end else if (ref_ins.is_eret) begin
        exp_eret = 1; exp_flush = 1; exp_fpc = epc;
      end else if (ref_ins.is_mtc0) begin
        exp_wen = 1;
      end else if (ref_ins.is_mfc0) begin
        exp_rfwe = (ref_ins.dest != 0);
        exp_rfd  = ref_cp0[{ref_ins.cp0_register, ref_ins.cp0_select}];
      end else begin
        exp_rfwe = (ref_ins.dest != 0);
        exp_rfd  = ref_ins.result;
      end
    end
    chk("ws_allow_in", 32'(ws_allow_in), 32'(!ref_drain));
    chk("flush", 32'(flush), 32'(exp_flush));
    chk("write_enabled", 32'(wb_to_cp0_data_bus.write_enabled), 32'(exp_wen));
    chk("exception_valid", 32'(wb_to_cp0_data_bus.exception_valid), 32'(exp_exc));
    chk("eret_flush", 32'(wb_to_cp0_data_bus.eret_flush), 32'(exp_eret));
    chk("rf_write_enable", 32'(rf_write_enable), 32'(exp_rfwe));
    if (exp_flush) chk("flush_pc", flush_pc, exp_fpc);
    if (exp_rfwe) begin
      chk("rf_write_address", 32'(rf_write_address), 32'(ref_ins.dest));
      chk("rf_write_data", rf_write_data, exp_rfd);
    end
    if (exp_wen) begin
      chk("cp0_address_register", 32'(wb_to_cp0_data_bus.address_register), 32'(ref_ins.cp0_register));
      chk("cp0_address_select", 32'(wb_to_cp0_data_bus.address_select), 32'(ref_ins.cp0_select));
      chk("cp0_write_data", wb_to_cp0_data_bus.write_data, ref_ins.rt_value);
      ref_cp0[{ref_ins.cp0_register, ref_ins.cp0_select}] = ref_ins.rt_value;
    end
    if (exp_exc) begin
      chk("exception_code", 32'(wb_to_cp0_data_bus.exception_code), 32'(ref_ins.exception_code));
      chk("exception_pc", wb_to_cp0_data_bus.exception_pc, ref_ins.pc);
      chk("in_delay_slot", 32'(wb_to_cp0_data_bus.in_delay_slot), 32'(ref_ins.in_delay_slot));
    end
    if (r) begin
      ref_held = 0; ref_drain = 0;
    end else if (ref_drain) begin
      ref_drain = 0; ref_held = 0;
    end else if (exp_flush) begin
      ref_held = 0; ref_drain = 1;
    end else if (v) begin
      ref_held = 1; ref_ins = b;
    end else begin
      ref_held = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic r, input logic [31:0] epc);
    cycle(1'b0, rnd_ins(), r, epc);
  endtask

  initial begin
    MSToWSData b;
    for (int i = 0; i < 256; i++) begin
      cp0_mem[i] = 32'h5a000000 ^ (i * 32'h00010101);
      ref_cp0[i] = 32'h5a000000 ^ (i * 32'h00010101);
    end
    cp0_mem[{5'd14, 3'd0}] = 32'h80001234;
    ref_cp0[{5'd14, 3'd0}] = 32'h80001234;
    ref_held = 0; ref_drain = 0; ref_ins = '0;
    reset = 1'b1; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; cp0_epc = 32'h0;
    @(posedge clock); @(posedge clock); #1;

    // reset state
    idle(1'b0, 32'h0);
    // mtc0 reg 12 sel 0
    cycle(1'b1, mk(1, 1'b0, 5'd3, 5'd12, 3'd0, 32'h0000ff01), 1'b0, 32'h0);
    idle(1'b0, 32'h0);
    // mfc0 reg 14 into dest 8
    cycle(1'b1, mk(2, 1'b0, 5'd8, 5'd14, 3'd0, 32'h0), 1'b0, 32'h0);
    idle(1'b0, 32'h0);
    // back-to-back mtc0 then mfc0 of the same register
    cycle(1'b1, mk(1, 1'b0, 5'd0, 5'd12, 3'd0, 32'hcafe0042), 1'b0, 32'h0);
    cycle(1'b1, mk(2, 1'b0, 5'd9, 5'd12, 3'd0, 32'h0), 1'b0, 32'h0);
    idle(1'b0, 32'h0);
    // exception, then offered instructions during commit and drain are dropped
    b = mk(0, 1'b1, 5'd4, 5'd12, 3'd0, 32'h0);
    b.exception_code = 5'h08; b.pc = 32'hbfc00100; b.in_delay_slot = 1'b1;
    cycle(1'b1, b, 1'b0, 32'h0);
    cycle(1'b1, mk(1, 1'b0, 5'd0, 5'd13, 3'd0, 32'h11111111), 1'b0, 32'h0);
    cycle(1'b1, mk(1, 1'b0, 5'd0, 5'd13, 3'd0, 32'h22222222), 1'b0, 32'h0);
    idle(1'b0, 32'h0);
    // eret
    cycle(1'b1, mk(3, 1'b0, 5'd0, 5'd14, 3'd0, 32'h0), 1'b0, 32'h0);
    idle(1'b0, 32'hbfc00200);
    idle(1'b0, 32'h0);
    idle(1'b0, 32'h0);
    // mtc0 with exception
    cycle(1'b1, mk(1, 1'b1, 5'd0, 5'd12, 3'd0, 32'hdeadbeef), 1'b0, 32'h0);
    idle(1'b0, 32'h0);
    idle(1'b0, 32'h0);
    // reset in DRAIN
    cycle(1'b1, mk(3, 1'b0, 5'd0, 5'd14, 3'd0, 32'h0), 1'b0, 32'h0);
    idle(1'b0, 32'h12345678);
    idle(1'b1, 32'h0);
    idle(1'b0, 32'h0);
    // reset while VALID with mtc0
    cycle(1'b1, mk(1, 1'b0, 5'd0, 5'd12, 3'd0, 32'h0badf00d), 1'b0, 32'h0);
    idle(1'b1, 32'h0);
    idle(1'b0, 32'h0);
    cycle(1'b1, mk(2, 1'b0, 5'd7, 5'd12, 3'd0, 32'h0), 1'b0, 32'h0);
    idle(1'b0, 32'h0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 3) != 0), rnd_ins(), ($urandom_range(0, 49) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_cp0_requester.md
Name: wb_cp0_requester

Overview:
- Writeback-stage front end that drives the CP0 access bus and consumes CP0 read data.
- Latches one retiring instruction from MEM, then issues one of the following for it:
  - an mtc0 write,
  - an mfc0 read (with regfile writeback),
  - an exception commit,
  - an eret commit.
- Generates the pipeline flush and redirect PC, then inserts one drain cycle before accepting new work.

Parameters:
- EXCEPTION_VECTOR, 32'hbfc00380, redirect target on exception commit.
- CPU_DATA_WIDTH, 32, datapath width (taken from cpu_core_params).

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ms_to_ws_valid  in  1  MEM offers an instruction
- ms_to_ws_bus  in  MSToWSData  pc[32], dest[5], result[32], is_mtc0, is_mfc0, is_eret, exception_valid, exception_code[5], in_delay_slot, cp0_register[5], cp0_select[3], rt_value[32]
- ws_allow_in  out  1  WB can accept this cycle
- wb_to_cp0_data_bus  out  WBToCP0Data  write_enabled, address_register[5], address_select[3], write_data[32], exception_valid, eret_flush, exception_code[5], exception_pc[32], in_delay_slot
- cp0_read_data  in  32  CP0 read result for the current address (combinational)
- cp0_epc  in  32  current EPC value
- rf_write_enable  out  1  regfile write strobe
- rf_write_address  out  5  regfile destination
- rf_write_data  out  32  regfile data
- flush  out  1  pipeline flush pulse
- flush_pc  out  32  redirect target, valid with flush

Behaviour:
- States:
  - EMPTY: no instruction held.
  - VALID: instruction held; completes this cycle.
  - DRAIN: one cycle after a flush.
- Reset:
  - State goes to EMPTY.
  - flush, rf_write_enable and every CP0 bus strobe (write_enabled, exception_valid, eret_flush) are 0.
  - Latched bus register contents are don't-care.
  - Reset asserted in any state, including DRAIN or mid-flush, overrides everything; no strobe may appear in the reset cycle.
- ws_allow_in:
  - 1 in EMPTY and VALID; 0 in DRAIN.
  - WB completes every instruction in one cycle, so VALID always accepts.
- Transitions:
  - EMPTY: on ms_to_ws_valid, latch ms_to_ws_bus and go to VALID.
  - VALID, commit is exception or eret: go to DRAIN.
  - VALID, otherwise with ms_to_ws_valid: latch and stay in VALID.
  - VALID, otherwise without ms_to_ws_valid: go to EMPTY.
  - DRAIN: go to EMPTY; ms_to_ws_valid is ignored and nothing is latched.
- All outputs are combinational from the VALID-state register.
  - Strobes are high for exactly one cycle per instruction.
  - Strobes are never high outside VALID.
- address_register and address_select always come from the latched bus; write_data = rt_value.
- Priority inside VALID (highest first):
  1. exception_valid: wb_to_cp0_data_bus.exception_valid=1; exception_code, exception_pc=pc and in_delay_slot forwarded; flush=1; flush_pc=EXCEPTION_VECTOR; write_enabled=0; rf_write_enable=0; eret_flush=0.
  2. is_eret: eret_flush=1; flush=1; flush_pc=cp0_epc sampled that same cycle; no regfile write.
  3. is_mtc0: write_enabled=1; rf_write_enable=0.
  4. is_mfc0: rf_write_enable=(dest!=0); rf_write_data=cp0_read_data; zero-cycle read latency.
  5. Otherwise: rf_write_enable=(dest!=0); rf_write_data=result.
- An exception on an mtc0/mfc0/eret instruction suppresses that instruction's CP0 write and regfile write.
- The decoded flags are assumed one-hot apart from exception_valid. If more than one of is_eret/is_mtc0/is_mfc0 is set, the priority order above decides the outcome; no error is raised.
- Back-to-back mtc0 then mfc0 to the same register: the mfc0 (VALID in the next cycle) must observe the new value. CP0 updates on the edge ending the mtc0 cycle.

Decomposition:
- coprocessor0_params:
  - WBToCP0Data struct, extended with exception_code, exception_pc, in_delay_slot.
  - Exception code constants.
  - EXCEPTION_VECTOR default.
- cpu_core_params:
  - MSToWSData struct.
  - WsState enum {EMPTY, VALID, DRAIN}.
- Sub-module: wb_commit_select, the combinational priority encoder that produces the CP0 bus, the regfile write and flush from the latched bus. The FSM and latch stay in the top module.

Test Plan:
1. mtc0 to reg 12 sel 0, rt_value=32'h0000ff01 -> one cycle with write_enabled=1, address_register=12, address_select=0, write_data=32'h0000ff01; rf_write_enable=0; flush=0.
2. mfc0 from reg 14 into dest 8 with cp0_read_data=32'h80001234 -> rf_write_enable=1, rf_write_address=8, rf_write_data=32'h80001234 in the same cycle; no CP0 strobe.
3. Exception, code 5'h08, pc=32'hbfc00100, in_delay_slot=1 -> exception_valid=1 and flush=1 for one cycle, flush_pc=32'hbfc00380; next cycle ws_allow_in=0 and the offered instruction is not latched (no strobe the cycle after).
4. eret with cp0_epc=32'hbfc00200 -> eret_flush=1, flush=1, flush_pc=32'hbfc00200, then one DRAIN cycle, then EMPTY.
5. mtc0 carrying exception_valid=1 -> write_enabled=0 and exception_valid=1.
6. Reset asserted during DRAIN and while VALID with mtc0 -> all strobes 0 in that cycle; state EMPTY; ws_allow_in=1 in the following cycle.
